ex_wb_skid_stage: RTL and testbench
===================================

// Module: ex_wb_skid_stage
// PURPOSE
//  Execute->writeback pipeline stage directly downstream of the Ex0 ALU result.
//  Captures the ALU result with its destination register in a 2-entry skid
//  buffer and presents it to writeback with a valid/ready handshake.
//  Breaks the ready path and exposes the youngest in-flight result to decode bypass.
// PARAMETERS
//  DATA_W  $bits(CpuType)=32  result width
//  RD_W    5                  destination register index width
// PORTS
//  iClk        in   1       single clock, all state on rising edge
//  iRst_n      in   1       reset, synchronous, active-low
//  iFlush      in   1       synchronous pipeline flush, drops all entries
//  iExValid    in   1       execute result valid
//  oExReady    out  1       stage can accept (registered)
//  iExResult   in   DATA_W  ALU result (Ex0 oResult)
//  iExRd       in   RD_W    destination register index
//  iExWrEn     in   1       result writes the register file
//  oWbValid    out  1       head entry valid toward writeback
//  iWbReady    in   1       writeback accepts head
//  oWbResult   out  DATA_W  head result
//  oWbRd       out  RD_W    head destination
//  oWbWrEn     out  1       head write enable, forced 0 when oWbRd==0
//  oFwdValid   out  1       youngest entry valid and writes a register
//  oFwdRd      out  RD_W    youngest entry destination
//  oFwdData    out  DATA_W  youngest entry result
//  oOccupancy  out  2       entries held: 0,1,2
// BEHAVIOUR
//  - Push = iExValid & oExReady. Pop = oWbValid & iWbReady. FIFO order always preserved.
//  - States EMPTY/ONE/FULL (head reg + skid reg).
//    EMPTY: push->ONE (head<=in).
//    ONE: push&pop->ONE (head<=in); push->FULL (skid<=in); pop->EMPTY.
//    FULL: pop->ONE (head<=skid); push impossible.
//  - Latency: accepted entry visible on oWbValid next cycle when buffer empty/draining.
//  - oExReady is a flop: next value = (next_state != FULL). No combinational path
//    from iWbReady to oExReady.
//  - oWbValid = state != EMPTY; oOccupancy = 0/1/2 for EMPTY/ONE/FULL.
//  - Write-enable masking: entries with rd==0 are stored with WrEn=0. Writes to x0 are never visible.
//  - Forwarding: the youngest entry is skid when FULL, head when ONE.
//    oFwdValid = entry valid & WrEn. oFwdRd/oFwdData are taken from that entry.
//    oFwdValid=0 when EMPTY.
//  - Flush: next state EMPTY and all valids cleared.
//    Flush overrides a simultaneous push; the pushed entry is dropped.
//    A simultaneous pop still completes at WB that cycle.
//    oExReady=1 the cycle after a flush.
//  - Reset (iRst_n=0 at edge): state EMPTY, oExReady=0, all data/rd/WrEn regs 0.
//    Hence oWbValid=0, oWbWrEn=0, oFwdValid=0, oOccupancy=0.
//    oExReady rises the first cycle after iRst_n returns high.
//    Reset overrides flush, push and pop.
//  - Data regs load only on push/shift; held otherwise. Outputs are never X after reset.
// STRUCTURE
//  - ZionDataType package: CpuType (existing); add RegIdxType logic[RD_W-1:0].
//  - ZionDataType package: add struct ExWbEntryType {Result, Rd, WrEn} and enum SkidStateType {EMPTY,ONE,FULL}.
//  - Single module, no sub-module; head and skid are two ExWbEntryType registers plus the state register.
// TESTING
//  1. iRst_n=0 for 2 cycles with iExValid=1
//     -> oWbValid=0, oExReady=0, all outputs 0; oExReady=1 first cycle after release.
//  2. iWbReady=1; push 0x11,0x22,0x33 back-to-back (rd=1,2,3)
//     -> WB sees each one cycle later in order; oExReady stays 1; occupancy <=1.
//  3. iWbReady=0; push 0xA,0xB -> FULL, oExReady=0, 0xC held at input.
//     Then iWbReady=1 -> WB receives 0xA,0xB,0xC in order with no loss/duplication.
//  4. Push 0xDEAD rd=0 WrEn=1 -> oWbValid=1, oWbWrEn=0, oFwdValid=0.
//  5. FULL with iFlush=1 and iExValid=1 same cycle -> next cycle oWbValid=0, occupancy 0,
//     oExReady=1; flushed/pushed entries never appear on WB.
//  6. iWbReady=0; push rd=5 data 1 then rd=5 data 2 -> oFwdRd=5, oFwdData=2.
//     After one pop -> oFwdData=2 from head.

Source files
------------

// File: rtl/ex_wb_skid_stage_pkg.sv
// Shared types for the execute->writeback skid stage: CPU word, register index,
// buffered entry record and skid buffer state encoding.
package ex_wb_skid_stage_pkg;

    typedef logic [31:0] CpuType;
    localparam int unsigned DATA_W = $bits(CpuType);
    localparam int unsigned RD_W   = 5;
    typedef logic [RD_W-1:0] RegIdxType;

    typedef struct packed {
        CpuType    result;
        RegIdxType rd;
        logic      wr_en;
    } ExWbEntryType;

    typedef logic [1:0] SkidStateType;
    localparam SkidStateType EMPTY = 2'd0;
    localparam SkidStateType ONE   = 2'd1;
    localparam SkidStateType FULL  = 2'd2;

    // x0 is hardwired zero, so an entry targeting it never writes.
    function automatic ExWbEntryType make_entry(CpuType result, RegIdxType rd, logic wr_en);
        ExWbEntryType e;
        e.result = result;
        e.rd     = rd;
        e.wr_en  = wr_en & (rd != '0);
        return e;
    endfunction

endpackage

// File: rtl/ex_wb_skid_stage.sv
// Two-entry skid buffer between the Ex0 ALU and writeback, with a registered
// ready toward execute and a bypass view of the youngest in-flight result.
module ex_wb_skid_stage
    import ex_wb_skid_stage_pkg::*;
(
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iFlush,
    input  logic              iExValid,
    output logic              oExReady,
    input  logic [DATA_W-1:0] iExResult,
    input  logic [RD_W-1:0]   iExRd,
    input  logic              iExWrEn,
    output logic              oWbValid,
    input  logic              iWbReady,
    output logic [DATA_W-1:0] oWbResult,
    output logic [RD_W-1:0]   oWbRd,
    output logic              oWbWrEn,
    output logic              oFwdValid,
    output logic [RD_W-1:0]   oFwdRd,
    output logic [DATA_W-1:0] oFwdData,
    output logic [1:0]        oOccupancy
);

    SkidStateType state_q, state_d;
    ExWbEntryType head_q, head_d;
    ExWbEntryType skid_q, skid_d;
    ExWbEntryType in_entry;
    ExWbEntryType fwd_entry;
    logic         ready_q, ready_d;
    logic         push, pop;

    assign in_entry = make_entry(iExResult, iExRd, iExWrEn);
    assign push     = iExValid & ready_q;
    assign pop      = (state_q != EMPTY) & iWbReady;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (iFlush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        head_d  = in_entry;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_d = in_entry;
                    end else if (push) begin
                        skid_d  = in_entry;
                        state_d = FULL;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // ready_q is low here, so push cannot occur
                    if (pop) begin
                        head_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        // Registered ready: depends only on next state, never on iWbReady combinationally
        ready_d = (state_d != FULL);
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state_q <= EMPTY;
            ready_q <= 1'b0;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    assign fwd_entry = (state_q == FULL) ? skid_q : head_q;

    assign oExReady   = ready_q;
    assign oWbValid   = (state_q != EMPTY);
    assign oWbResult  = head_q.result;
    assign oWbRd      = head_q.rd;
    assign oWbWrEn    = head_q.wr_en;
    assign oFwdValid  = (state_q != EMPTY) & fwd_entry.wr_en;
    assign oFwdRd     = fwd_entry.rd;
    assign oFwdData   = fwd_entry.result;
    assign oOccupancy = (state_q == FULL) ? 2'd2 : (state_q == ONE) ? 2'd1 : 2'd0;

endmodule

// File: tb/tb_ex_wb_skid_stage.sv
// Bench for ex_wb_skid_stage: directed vector table, hand sequences for flush and
// forwarding, then random traffic checked against a queue-based reference model.
module tb_ex_wb_skid_stage;

    logic        clk;
    logic        rst_n, flush, ex_valid, ex_wren, wb_ready;
    logic [31:0] ex_result;
    logic [4:0]  ex_rd;
    logic        ex_ready, wb_valid, wb_wren, fwd_valid;
    logic [31:0] wb_result, fwd_data;
    logic [4:0]  wb_rd, fwd_rd;
    logic [1:0]  occupancy;

    int n_checks = 0;
    int n_fails  = 0;

    ex_wb_skid_stage dut (
        .iClk       (clk),
        .iRst_n     (rst_n),
        .iFlush     (flush),
        .iExValid   (ex_valid),
        .oExReady   (ex_ready),
        .iExResult  (ex_result),
        .iExRd      (ex_rd),
        .iExWrEn    (ex_wren),
        .oWbValid   (wb_valid),
        .iWbReady   (wb_ready),
        .oWbResult  (wb_result),
        .oWbRd      (wb_rd),
        .oWbWrEn    (wb_wren),
        .oFwdValid  (fwd_valid),
        .oFwdRd     (fwd_rd),
        .oFwdData   (fwd_data),
        .oOccupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an ordered queue of at most two entries plus a ready bit.
    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        wren;
    } ent_t;
    ent_t mq[$];
    logic m_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_check();
        logic fv;
        chk("occupancy", 32'(occupancy), 32'(mq.size()));
        chk("wb_valid", 32'(wb_valid), 32'(mq.size() != 0));
        chk("ex_ready", 32'(ex_ready), 32'(m_ready));
        fv = 1'b0;
        if (mq.size() != 0) begin
            chk("wb_result", wb_result, mq[0].res);
            chk("wb_rd", 32'(wb_rd), 32'(mq[0].rd));
            chk("wb_wren", 32'(wb_wren), 32'(mq[0].wren));
            fv = mq[mq.size()-1].wren;
        end
        chk("fwd_valid", 32'(fwd_valid), 32'(fv));
        if (fv) begin
            chk("fwd_rd", 32'(fwd_rd), 32'(mq[mq.size()-1].rd));
            chk("fwd_data", fwd_data, mq[mq.size()-1].res);
        end
    endtask

    // Called at a negedge: drive, clock, update model, then compare at the next negedge.
    task automatic cycle(input logic r, input logic f, input logic v, input logic [31:0] res,
                         input logic [4:0] rd, input logic w, input logic b);
        logic m_push, m_pop;
        ent_t e;
        rst_n = r; flush = f; ex_valid = v; ex_result = res; ex_rd = rd; ex_wren = w;
        wb_ready = b;
        m_pop  = (mq.size() != 0) && b;
        m_push = v && m_ready;
        @(posedge clk);
        if (!r) begin
            mq.delete();
            m_ready = 1'b0;
        end else begin
            if (f) begin
                mq.delete();
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_push) begin
                    e.res  = res;
                    e.rd   = rd;
                    e.wren = w && (rd != 5'd0);
                    mq.push_back(e);
                end
            end
            m_ready = (mq.size() < 2);
        end
        @(negedge clk);
        model_check();
    endtask

    typedef struct {
        logic        rst_n, flush, valid;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        wren, wb_ready;
        logic        e_wbvalid, e_ready;
        logic [1:0]  e_occ;
        logic [31:0] e_wbres;
        logic        e_wbwren, e_fwdvalid;
        logic [31:0] e_fwddata;
    } vec_t;
    vec_t vecs[15];

    initial begin
        // reset x2 with valid high, release, back-to-back flow, fill/drain, x0 masking
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 32'h55,   5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0,   1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 32'h55,   5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0,   1'b0, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,    5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0,   1'b0, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 32'h11,   5'd1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 32'h11,  1'b1, 1'b1, 32'h11};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 32'h22,   5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 32'h22,  1'b1, 1'b1, 32'h22};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 32'h33,   5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 32'h33,  1'b1, 1'b1, 32'h33};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,    5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0,   1'b0, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 32'hA,    5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'hA,   1'b1, 1'b1, 32'hA};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'hB,    5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 32'hA,   1'b1, 1'b1, 32'hB};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'hC,    5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 32'hA,   1'b1, 1'b1, 32'hB};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 32'hC,    5'd4, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 32'hB,   1'b1, 1'b1, 32'hB};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 32'hC,    5'd4, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 32'hC,   1'b1, 1'b1, 32'hC};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 32'h0,    5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0,   1'b0, 1'b0, 32'h0};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 32'hDEAD, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'hDEAD, 1'b0, 1'b0, 32'h0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 32'h0,    5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0,   1'b0, 1'b0, 32'h0};

        rst_n = 1'b0; flush = 1'b0; ex_valid = 1'b0; ex_result = '0; ex_rd = '0;
        ex_wren = 1'b0; wb_ready = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            cycle(vecs[i].rst_n, vecs[i].flush, vecs[i].valid, vecs[i].res, vecs[i].rd,
                  vecs[i].wren, vecs[i].wb_ready);
            chk($sformatf("v%0d.wb_valid", i), 32'(wb_valid), 32'(vecs[i].e_wbvalid));
            chk($sformatf("v%0d.ex_ready", i), 32'(ex_ready), 32'(vecs[i].e_ready));
            chk($sformatf("v%0d.occ", i), 32'(occupancy), 32'(vecs[i].e_occ));
            chk($sformatf("v%0d.fwd_valid", i), 32'(fwd_valid), 32'(vecs[i].e_fwdvalid));
            if (vecs[i].e_wbvalid || !vecs[i].rst_n) begin
                chk($sformatf("v%0d.wb_result", i), wb_result, vecs[i].e_wbres);
                chk($sformatf("v%0d.wb_wren", i), 32'(wb_wren), 32'(vecs[i].e_wbwren));
            end
            if (vecs[i].e_fwdvalid || !vecs[i].rst_n)
                chk($sformatf("v%0d.fwd_data", i), fwd_data, vecs[i].e_fwddata);
            if (!vecs[i].rst_n) begin
                chk($sformatf("v%0d.wb_rd", i), 32'(wb_rd), 32'h0);
                chk($sformatf("v%0d.fwd_rd", i), 32'(fwd_rd), 32'h0);
            end
        end

        // Flush while full with a simultaneous push: everything is dropped
        cycle(1'b1, 1'b0, 1'b1, 32'hE1, 5'd9, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 32'hE2, 5'd9, 1'b1, 1'b0);
        chk("flush.pre_occ", 32'(occupancy), 32'd2);
        cycle(1'b1, 1'b1, 1'b1, 32'hE3, 5'd9, 1'b1, 1'b0);
        chk("flush.wb_valid", 32'(wb_valid), 32'h0);
        chk("flush.occ", 32'(occupancy), 32'h0);
        chk("flush.ex_ready", 32'(ex_ready), 32'h1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
            chk("flush.no_leak", 32'(wb_valid), 32'h0);
        end

        // Forwarding tracks the youngest entry
        cycle(1'b1, 1'b0, 1'b1, 32'd1, 5'd5, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 32'd2, 5'd5, 1'b1, 1'b0);
        chk("fwd.rd", 32'(fwd_rd), 32'd5);
        chk("fwd.data_full", fwd_data, 32'd2);
        chk("fwd.wb_head", wb_result, 32'd1);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
        chk("fwd.data_one", fwd_data, 32'd2);
        chk("fwd.valid_one", 32'(fwd_valid), 32'h1);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b1);

        // Random traffic against the queue model
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(99) != 0), ($urandom_range(19) == 0),
                  ($urandom_range(3) != 0), $urandom(), 5'($urandom_range(7)),
                  ($urandom_range(3) != 0), ($urandom_range(2) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
